// File: rtl/chargen.sv
// RFC 864 character generator. Emits LINE_LEN printable characters per line
// followed by CR LF over a valid/ready byte interface. Each line starts one
// character later in the FIRST..LAST rotation than the previous line.
module chargen #(
  parameter int unsigned LINE_LEN = 72,
  parameter logic [7:0]  FIRST    = 8'h20,
  parameter logic [7:0]  LAST     = 8'h7E
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        ready,
  output logic [7:0]  data,
  output logic        valid,
  output logic [15:0] lines
);

  // state_q names the kind of byte being offered (valid=1) or the kind of
  // byte to offer on resume (valid=0). IDLE means "start of a line".
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CHAR = 2'd1;
  localparam logic [1:0] CR   = 2'd2;
  localparam logic [1:0] LF   = 2'd3;

  localparam logic [7:0] LAST_COL = 8'(LINE_LEN - 1);
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  logic [1:0]  state_q, state_d;
  logic [7:0]  col_q, col_d;
  logic [7:0]  char_q, char_d;
  logic [7:0]  start_q, start_d;
  logic [15:0] lines_q, lines_d;
  logic        valid_q, valid_d;
  logic [7:0]  data_q, data_d;
  logic        xfer;

  // Next character in the rotation, wrapping LAST back to FIRST.
  function automatic logic [7:0] next_char(input logic [7:0] c);
    return (c == LAST) ? FIRST : c + 8'd1;
  endfunction

  // Byte presented for a given position in the stream.
  function automatic logic [7:0] byte_for(input logic [1:0] st, input logic [7:0] c);
    case (st)
      CR:      return ASCII_CR;
      LF:      return ASCII_LF;
      default: return c;
    endcase
  endfunction

  assign xfer = valid_q && ready;

  // Next-state logic: advance the stream position only on a transfer, and
  // offer a new byte whenever en is high and nothing is pending.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    col_d   = col_q;
    char_d  = char_q;
    start_d = start_q;
    lines_d = lines_q;
    valid_d = valid_q;
    data_d  = data_q;

    if (xfer) begin
      case (state_q)
        CHAR: begin
          char_d = next_char(char_q);
          if (col_q == LAST_COL) state_d = CR;
          else                   col_d   = col_q + 8'd1;
        end
        CR: state_d = LF;
        LF: begin
          start_d = next_char(start_q);
          char_d  = next_char(start_q);
          col_d   = 8'd0;
          lines_d = lines_q + 16'd1;
          state_d = en ? CHAR : IDLE;
        end
        default: ;
      endcase
      // en low lets the current byte finish, then the stream pauses here.
      valid_d = en;
    end else if (!valid_q && en) begin
      valid_d = 1'b1;
      if (state_q == IDLE) state_d = CHAR;
    end

    // Data only changes when a new byte is offered; a held byte recomputes
    // from unchanged position state and so stays put.
    if (valid_d) data_d = byte_for(state_d, char_d);
  end

  // State registers; reset forces the stream back to line 0, character FIRST.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      col_q   <= 8'd0;
      char_q  <= FIRST;
      start_q <= FIRST;
      lines_q <= 16'd0;
      valid_q <= 1'b0;
      data_q  <= 8'h00;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      col_q   <= col_d;
      char_q  <= char_d;
      start_q <= start_d;
      lines_q <= lines_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign data  = data_q;
  assign valid = valid_q;
  assign lines = lines_q;

endmodule

// File: doc/chargen.md
CHARGEN -- requirements
Module: chargen

Interface
REQ-001 Parameter LINE_LEN, default 72: printable characters per line before CR LF; legal range 1..255.
REQ-002 Parameter FIRST, default 8'h20: lowest character in the rotation.
REQ-003 Parameter LAST, default 8'h7E: highest character in the rotation; FIRST < LAST required.
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 en  in  1  run enable; sampled on clk.
REQ-007 data  out  8  ASCII byte offered downstream (FIFO write side).
REQ-008 valid  out  1  data holds a byte for transfer.
REQ-009 ready  in  1  downstream can accept; transfer = valid && ready on a rising edge.
REQ-010 lines  out  16  count of completed lines (LF transferred); wraps 16'hFFFF -> 0.

Function
REQ-011 The output stream shall follow the RFC 864 pattern: line k = LINE_LEN consecutive characters starting at FIRST + (k mod N), N = LAST-FIRST+1, then 8'h0D, then 8'h0A.
REQ-012 The character sequence shall wrap LAST -> FIRST, both within a line and when advancing the line start.
REQ-013 FSM states: IDLE, CHAR, CR, LF; reset state IDLE.
REQ-014 IDLE: valid=0; en=1 -> CHAR with valid=1 on the next edge (latency 1 cycle from en sampled high to first valid).
REQ-015 CHAR: on transfer, col increments; when col = LINE_LEN-1 is transferred -> CR.
REQ-016 CR: data=8'h0D; on transfer -> LF.
REQ-017 LF: data=8'h0A; on transfer: line start advances by one (with wrap), col=0, lines increments, next state CHAR (en=1) or IDLE (en=0).
REQ-018 Data/valid shall be registered and shall not change while valid=1 and ready=0 (no retraction, no data change).
REQ-019 Back-to-back transfers shall be possible: with ready held high and en high, one byte per cycle, no bubbles, including across CR/LF and line boundaries.
REQ-020 en=0 shall not abort an offered byte; valid stays high until transferred. After that transfer the block pauses (valid=0), keeping col, current character, line start and FSM position; en=1 resumes the stream exactly where it stopped (latency 1 cycle).
REQ-021 A pause taken inside CHAR or after CR shall resume at the next character of the same line, or at LF, respectively.
REQ-022 ready shall be ignored while valid=0; no state advances without a transfer.
REQ-023 Full stream period shall be N*(LINE_LEN+2) beats (7030 at defaults), after which output repeats from line 0.

Reset
REQ-024 rst high shall immediately force valid=0, data=8'h00, lines=0, state IDLE, col=0, current character=FIRST, line start=FIRST, regardless of clk.
REQ-025 rst asserted mid-line or while valid=1 and ready=0 shall discard the pending byte; after release the stream restarts at line 0, character FIRST.
REQ-026 The first rising edge after rst deasserts shall be treated as an ordinary edge (en sampled normally).

Verification
REQ-027 Reset then en=1, ready=1 for 74 cycles -> valid rises one cycle after en; bytes 8'h20..8'h67 (72 beats), 8'h0D, 8'h0A; lines=1.
REQ-028 Continue to line 24 (index 24) -> starts 8'h38, runs to 8'h7E, 72nd byte wraps to 8'h20, then 0D 0A; after 7030 total beats line 95 starts 8'h20 again, lines=95.
REQ-029 Toggle ready pseudo-randomly while streaming -> data/valid stable while ready=0; transferred sequence identical to REQ-027/028 reference model.
REQ-030 Drop en after the 10th transfer with ready=0 on the 11th byte -> valid held with 8'h2A until ready=1, then valid=0; re-raise en -> next byte 8'h2B after 1 cycle.
REQ-031 Assert rst asynchronously (between edges) mid-line with valid=1, ready=0 -> valid=0, lines=0 immediately; after release with en=1 the first byte is 8'h20.
REQ-032 LINE_LEN=1, FIRST=8'h41, LAST=8'h43 -> stream 41 0D 0A 42 0D 0A 43 0D 0A 41 ..., lines increments every 3 beats.
